// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - parametrised universal shift register with burst engine
//
// Purpose:
//   Eight single-step modes (hold, shr, shl, load, rotr, rotl, asr, clear) and a
//   burst engine that repeats one latched shift/rotate mode cnt times autonomously.
//   Optional parity output is built only when USR_PARITY_EN is defined.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   i       parallel load data
//   s       mode select
//   r       serial fill bit (shr into MSB, shl into LSB)
//   cnt     burst shift count, sampled with start
//   start   burst request, honoured in IDLE only
//   o       register contents
//   so      last bit shifted or rotated out
//   busy    high while a burst is running
//   done    one-cycle pulse on burst completion
//   parity  ^o (USR_PARITY_EN only)

module universal_shift_register #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i,
   input  logic [2:0]       s,
   input  logic             r,
   input  logic [CNT_W-1:0] cnt,
   input  logic             start,
   output logic [WIDTH-1:0] o,
   output logic             so,
   output logic             busy,
   output logic             done
`ifdef USR_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_SHR   = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_LOAD  = 3'b011;
   localparam logic [2:0] M_ROTR  = 3'b100;
   localparam logic [2:0] M_ROTL  = 3'b101;
   localparam logic [2:0] M_ASR   = 3'b110;
   localparam logic [2:0] M_CLEAR = 3'b111;

   logic [0:0]       state;
   logic [2:0]       mode_q;
   logic [CNT_W-1:0] rem_q;

   logic [2:0]       op;
   logic [WIDTH-1:0] nxt_o;
   logic             nxt_so;
   logic             s_is_shift;

   // Only modes that move bits out of the register may be run as a burst.
   assign s_is_shift = (s == M_SHR) || (s == M_SHL) || (s == M_ROTR) ||
                       (s == M_ROTL) || (s == M_ASR);

   // During a burst the latched mode drives the datapath and s is ignored.
   assign op = (state == RUN) ? mode_q : s;

   always_comb begin
      nxt_o  = o;
      nxt_so = so;
      case (op)
         M_HOLD:  nxt_o = o;
         M_SHR:   begin nxt_o = {r, o[WIDTH-1:1]};        nxt_so = o[0];       end
         M_SHL:   begin nxt_o = {o[WIDTH-2:0], r};        nxt_so = o[WIDTH-1]; end
         M_LOAD:  nxt_o = i;
         M_ROTR:  begin nxt_o = {o[0], o[WIDTH-1:1]};     nxt_so = o[0];       end
         M_ROTL:  begin nxt_o = {o[WIDTH-2:0], o[WIDTH-1]}; nxt_so = o[WIDTH-1]; end
         M_ASR:   begin nxt_o = {o[WIDTH-1], o[WIDTH-1:1]}; nxt_so = o[0];     end
         M_CLEAR: nxt_o = '0;
         default: nxt_o = o;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         mode_q <= M_HOLD;
         rem_q  <= '0;
         o      <= '0;
         so     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start && (cnt == '0)) begin
               // Empty burst: acknowledge without touching the register.
               done <= 1'b1;
            end else if (start && s_is_shift) begin
               // The start edge only arms the burst; the first op happens next edge.
               mode_q <= s;
               rem_q  <= cnt;
               busy   <= 1'b1;
               state  <= RUN;
            end else begin
               o  <= nxt_o;
               so <= nxt_so;
               if (start) begin
                  done <= 1'b1;
               end
            end
         end else begin
            o     <= nxt_o;
            so    <= nxt_so;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
         end
      end
   end

`ifdef USR_PARITY_EN
   assign parity = ^o;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - self-checking bench for universal_shift_register

module tb_universal_shift_register;

   localparam int W  = 8;
   localparam int CW = 4;
   localparam int MOD = 1 << W;
   localparam int MSBV = 1 << (W - 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  i;
   logic [2:0]    s;
   logic          r;
   logic [CW-1:0] cnt;
   logic          start;
   logic [W-1:0]  o;
   logic          so;
   logic          busy;
   logic          done;
`ifdef USR_PARITY_EN
   logic          parity;
`endif

   int total = 0;
   int bad   = 0;

   int m_o  = 0;
   int m_so = 0;

   universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .i     (i),
      .s     (s),
      .r     (r),
      .cnt   (cnt),
      .start (start),
      .o     (o),
      .so    (so),
      .busy  (busy),
      .done  (done)
`ifdef USR_PARITY_EN
      ,
      .parity(parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour using integer arithmetic on the register value.
   task automatic model_op(input int mode, input int rb, input int ld);
      int lsb, msb;
      lsb = m_o % 2;
      msb = m_o / MSBV;
      case (mode)
         1: begin m_so = lsb; m_o = m_o / 2 + rb * MSBV;       end
         2: begin m_so = msb; m_o = (m_o * 2) % MOD + rb;      end
         3: m_o = ld;
         4: begin m_so = lsb; m_o = m_o / 2 + lsb * MSBV;      end
         5: begin m_so = msb; m_o = (m_o * 2) % MOD + msb;     end
         6: begin m_so = lsb; m_o = m_o / 2 + msb * MSBV;      end
         7: m_o = 0;
         default: ;
      endcase
   endtask

   task automatic chk_all(input string tag, input logic eb, input logic ed);
      chk({tag, ".o"}, 32'(o), 32'(m_o));
      chk({tag, ".so"}, 32'(so), 32'(m_so));
      chk({tag, ".busy"}, 32'(busy), 32'(eb));
      chk({tag, ".done"}, 32'(done), 32'(ed));
`ifdef USR_PARITY_EN
      chk({tag, ".parity"}, 32'(parity), 32'($countones(m_o) % 2));
`endif
   endtask

   task automatic load(input int v);
      s = 3'b011;
      i = W'(v);
      start = 1'b0;
      tick();
      model_op(3, 0, v);
   endtask

   initial begin
      int modes[5];
      int md, n, rb;
      modes = '{1, 2, 4, 5, 6};
      reset = 1'b0; i = '0; s = 3'b000; r = 1'b0; cnt = '0; start = 1'b0;

      // 1. reset and release
      tick(); tick();
      chk_all("reset", 1'b0, 1'b0);
      reset = 1'b1;
      tick(); tick();
      chk_all("post_reset_hold", 1'b0, 1'b0);

      // 2. load then shr with r=1
      load(8'hA5);
      chk("load_a5", 32'(o), 32'h A5);
      s = 3'b001; r = 1'b1; tick(); model_op(1, 1, 0);
      chk("shr_d2", 32'(o), 32'hD2);
      chk("shr_so", 32'(so), 32'd1);
      chk_all("shr_model", 1'b0, 1'b0);

      // 3. single steps
      load(8'h7B); s = 3'b101; tick(); model_op(5, 0, 0);
      chk("rotl_f6", 32'(o), 32'hF6);
      chk_all("rotl", 1'b0, 1'b0);
      load(8'h7B); s = 3'b100; tick(); model_op(4, 0, 0);
      chk("rotr_bd", 32'(o), 32'hBD);
      chk_all("rotr", 1'b0, 1'b0);
      load(8'h85); s = 3'b110; tick(); model_op(6, 0, 0);
      chk("asr_c2", 32'(o), 32'hC2);
      chk_all("asr", 1'b0, 1'b0);
      load(8'hA5); s = 3'b111; tick(); model_op(7, 0, 0);
      chk("clear_00", 32'(o), 32'h00);
      chk_all("clear", 1'b0, 1'b0);
      s = 3'b000; r = 1'b1; tick();
      chk_all("hold", 1'b0, 1'b0);

      // 4. directed burst: shl x3 from 01, s toggled randomly afterwards
      load(8'h01);
      s = 3'b010; r = 1'b0; cnt = 4'd3; start = 1'b1;
      tick();
      chk_all("burst_arm", 1'b1, 1'b0);
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         s = 3'($urandom);
         tick();
         model_op(2, 0, 0);
         chk_all("burst_step", (k < 3), (k == 3));
      end
      chk("burst_final", 32'(o), 32'h08);
      s = 3'b000; tick();
      chk_all("burst_after", 1'b0, 1'b0);

      // randomized bursts with live r, stray starts and noisy s/i during RUN
      for (int t = 0; t < 8; t++) begin
         load($urandom % MOD);
         md = modes[$urandom % 5];
         n = (t == 0) ? 15 : $urandom_range(1, 15);
         s = 3'(md); cnt = CW'(n); start = 1'b1;
         tick();
         chk_all("rb_arm", 1'b1, 1'b0);
         for (int k = 1; k <= n; k++) begin
            rb = $urandom % 2;
            r = rb[0];
            s = 3'($urandom);
            i = W'($urandom);
            start = (($urandom % 4) == 0);
            cnt = CW'($urandom);
            tick();
            model_op(md, rb, 0);
            chk_all("rb_step", (k < n), (k == n));
         end
         start = 1'b0; s = 3'b000;
         tick();
         chk_all("rb_idle", 1'b0, 1'b0);
      end

      // 5. start with cnt=0, and start with a non-shift mode
      load(8'h3C);
      s = 3'b001; cnt = 4'd0; start = 1'b1;
      tick();
      chk_all("cnt0_done", 1'b0, 1'b1);
      start = 1'b0; s = 3'b000;
      tick();
      chk_all("cnt0_after", 1'b0, 1'b0);
      s = 3'b011; i = 8'h5A; cnt = 4'd5; start = 1'b1;
      tick(); model_op(3, 0, 8'h5A);
      chk_all("start_load", 1'b0, 1'b1);
      start = 1'b0; s = 3'b000;
      tick();
      chk_all("start_load_after", 1'b0, 1'b0);

      // 6. reset mid-burst
      load(8'h01);
      s = 3'b101; cnt = 4'd10; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         model_op(5, 0, 0);
      end
      chk_all("pre_abort", 1'b1, 1'b0);
      #2 reset = 1'b0;
      #1;
      m_o = 0; m_so = 0;
      chk_all("abort", 1'b0, 1'b0);
      tick(); tick();
      reset = 1'b1; s = 3'b000;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk_all("post_abort", 1'b0, 1'b0);
      end

`ifdef USR_PARITY_EN
      load(8'h01);
      chk("parity_01", 32'(parity), 32'd1);
      load(8'hA5);
      chk("parity_a5", 32'(parity), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
